// File: rtl/data_sram_responder.sv
// SRAM-style data port responder: one-cycle registered reads, byte-lane writes,
// sticky out-of-window error capture and a saturating access counter.
module data_sram_responder #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          AW   = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        rd_valid,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [31:0] acc_cnt
);

    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [0:DEPTH-1];
    logic [AW-1:0] idx;
    logic          inRange;
    logic          isRead;
    logic          isWrite;

    logic [31:0] rdata_q,    rdata_d;
    logic        rdValid_q,  rdValid_d;
    logic        err_q,      err_d;
    logic [31:0] errAddr_q,  errAddr_d;
    logic [31:0] accCnt_q,   accCnt_d;

    assign idx     = sram_addr[AW+1:2];
    assign inRange = (sram_addr[31:AW+2] == BASE[31:AW+2]);
    assign isRead  = sram_en && (sram_we == 4'b0000);
    assign isWrite = sram_en && inRange && (sram_we != 4'b0000);

    // Out-of-window reads return zero but still complete, so the CPU never stalls.
    always_comb begin
        rdata_d   = rdata_q;
        rdValid_d = 1'b0;
        err_d     = err_q;
        errAddr_d = errAddr_q;
        accCnt_d  = accCnt_q;
        if (sram_en) begin
            if (accCnt_q != 32'hFFFF_FFFF) begin
                accCnt_d = accCnt_q + 32'd1;
            end
            if (!inRange) begin
                err_d = 1'b1;
                if (!err_q) begin
                    errAddr_d = sram_addr;
                end
            end
        end
        if (isRead) begin
            rdValid_d = 1'b1;
            rdata_d   = inRange ? mem[idx] : 32'h0000_0000;
        end
    end

    // The RAM shares this block so that no write can land while reset is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'h0000_0000;
            rdValid_q <= 1'b0;
            err_q     <= 1'b0;
            errAddr_q <= 32'h0000_0000;
            accCnt_q  <= 32'h0000_0000;
        end else begin
            rdata_q   <= rdata_d;
            rdValid_q <= rdValid_d;
            err_q     <= err_d;
            errAddr_q <= errAddr_d;
            accCnt_q  <= accCnt_d;
            if (isWrite) begin
                for (int i = 0; i < 4; i++) begin
                    if (sram_we[i]) begin
                        mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign sram_rdata = rdata_q;
    assign rd_valid   = rdValid_q;
    assign err        = err_q;
    assign err_addr   = errAddr_q;
    assign acc_cnt    = accCnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder: byte writes, back-to-back
// hazards, window decode, address low bits, counter saturation and async reset.
module tb_data_sram_responder;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam int          AW     = 12;
    localparam logic [31:0] WINEND = 32'h1000_4000;
    localparam logic [31:0] LASTW  = 32'h1000_3FFC;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        rd_valid;
    logic        err;
    logic [31:0] err_addr;
    logic [31:0] acc_cnt;

    int compared;
    int mismatched;
    logic [31:0] expCnt;

    data_sram_responder #(.BASE(BASE), .AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .rd_valid   (rd_valid),
        .err        (err),
        .err_addr   (err_addr),
        .acc_cnt    (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's request at a negedge and returns at the following negedge.
    task automatic applyStimulus(input logic en, input logic [3:0] we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        sram_en    = en;
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wdata;
        if (en && expCnt != 32'hFFFF_FFFF) expCnt++;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        expCnt     = 32'h0;
        resetn     = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        #1;
        checkOutput("rst_rdata", sram_rdata, 32'h0);
        checkOutput("rst_rdvalid", {31'b0, rd_valid}, 32'h0);
        checkOutput("rst_err", {31'b0, err}, 32'h0);
        checkOutput("rst_erraddr", err_addr, 32'h0);
        checkOutput("rst_cnt", acc_cnt, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle();

        // Byte-lane merge
        applyStimulus(1'b1, 4'hF, BASE + 32'd8, 32'h1122_3344);
        checkOutput("wr_rdvalid", {31'b0, rd_valid}, 32'h0);
        applyStimulus(1'b1, 4'b0101, BASE + 32'd8, 32'hAABB_CCDD);
        applyStimulus(1'b1, 4'h0, BASE + 32'd8, 32'h0);
        checkOutput("byte_rdata", sram_rdata, 32'h11BB_33DD);
        checkOutput("byte_rdvalid", {31'b0, rd_valid}, 32'h1);
        idle();
        checkOutput("byte_rdvalid_drop", {31'b0, rd_valid}, 32'h0);
        checkOutput("byte_rdata_hold", sram_rdata, 32'h11BB_33DD);

        // Write then immediate read of the same word
        applyStimulus(1'b1, 4'hF, BASE + 32'd4, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'h0, BASE + 32'd4, 32'h0);
        checkOutput("b2b_rdata", sram_rdata, 32'hDEAD_BEEF);
        checkOutput("b2b_rdvalid", {31'b0, rd_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("b2b_idle_rdata", sram_rdata, 32'hDEAD_BEEF);
            checkOutput("b2b_idle_rdvalid", {31'b0, rd_valid}, 32'h0);
        end
        checkOutput("cnt_mid", acc_cnt, expCnt);

        // Address bits [1:0] are ignored
        applyStimulus(1'b1, 4'hF, BASE, 32'h1234_5678);
        applyStimulus(1'b1, 4'hF, LASTW, 32'hCAFE_F00D);
        applyStimulus(1'b1, 4'h1, BASE + 32'd3, 32'h0000_00A5);
        applyStimulus(1'b1, 4'h0, BASE, 32'h0);
        checkOutput("lowbits_rdata", sram_rdata, 32'h1234_56A5);

        // Window decode
        checkOutput("pre_err", {31'b0, err}, 32'h0);
        applyStimulus(1'b1, 4'h0, WINEND, 32'h0);
        checkOutput("oor_rdata", sram_rdata, 32'h0);
        checkOutput("oor_rdvalid", {31'b0, rd_valid}, 32'h1);
        checkOutput("oor_err", {31'b0, err}, 32'h1);
        applyStimulus(1'b1, 4'hF, BASE - 32'd4, 32'h5555_5555);
        checkOutput("oor_wr_rdvalid", {31'b0, rd_valid}, 32'h0);
        checkOutput("oor_err2", {31'b0, err}, 32'h1);
        checkOutput("oor_erraddr", err_addr, WINEND);
        applyStimulus(1'b1, 4'h0, BASE, 32'h0);
        checkOutput("oor_mem0", sram_rdata, 32'h1234_56A5);
        applyStimulus(1'b1, 4'h0, LASTW, 32'h0);
        checkOutput("oor_memlast", sram_rdata, 32'hCAFE_F00D);
        checkOutput("oor_err_sticky", {31'b0, err}, 32'h1);
        checkOutput("cnt_oor", acc_cnt, expCnt);

        // Saturation: preload the counter just below the ceiling
        dut.accCnt_q = 32'hFFFF_FFFE;
        expCnt       = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h0, BASE + 32'd8, 32'h0);
            checkOutput("cnt_sat", acc_cnt, expCnt);
        end
        idle();
        checkOutput("cnt_sat_hold", acc_cnt, 32'hFFFF_FFFF);

        // Asynchronous reset mid-cycle, with a write held across the reset
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_rdata", sram_rdata, 32'h0);
        checkOutput("arst_rdvalid", {31'b0, rd_valid}, 32'h0);
        checkOutput("arst_err", {31'b0, err}, 32'h0);
        checkOutput("arst_erraddr", err_addr, 32'h0);
        checkOutput("arst_cnt", acc_cnt, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 4'hF, BASE, 32'hFFFF_FFFF);
        resetn = 1'b1;
        expCnt = 32'h0;
        applyStimulus(1'b1, 4'h0, BASE, 32'h0);
        checkOutput("arst_mem_kept", sram_rdata, 32'h1234_56A5);
        checkOutput("arst_cnt_after", acc_cnt, expCnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
